sub_word_store: RTL and testbench

SUB_WORD_STORE -- requirements
Module: sub_word_store

---
 rtl/sub_word_store.sv | 124 ++++++++++++
 tb/tb_sub_word_store.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sub_word_store.sv
// Byte/half/word store engine over a word-wide memory port.
// Sub-word stores read the word, merge the new lanes in, and write the result back.
module sub_word_store #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_wr_o,
    output logic [31:0] mem_wdata_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [2:0] LAST_WAIT = 3'(RD_LATENCY - 1);

    logic [2:0]  state_reg;
    logic [2:0]  wait_cnt_reg;
    logic [1:0]  offset_reg;
    logic [1:0]  size_reg;
    logic [31:0] data_reg;
    logic        err_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] wdata_reg;

    logic        req_err;
    logic [3:0]  byte_en;
    logic [31:0] merged_word;

    // Reserved size or a half/word that does not sit on its natural boundary.
    assign req_err = (size_i == 2'b11) ||
                     (size_i == 2'b01 && addr_i[0]) ||
                     (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    always_comb begin
        byte_en = 4'b0000;
        case (size_reg)
            2'b00:   byte_en = 4'b0001 << offset_reg;
            2'b01:   byte_en = offset_reg[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b0000;
        endcase
    end

    // Byte stores replicate data[7:0] into every lane; half stores place data[15:0] in both halves.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_data;
        assign lane_data = (size_reg == 2'b00) ? data_reg[7:0] : data_reg[8*(gi%2) +: 8];
        assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data : mem_rdata_i[8*gi +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 3'd0;
            offset_reg   <= 2'b00;
            size_reg     <= 2'b00;
            data_reg     <= 32'd0;
            err_reg      <= 1'b0;
            mem_addr_reg <= 32'd0;
            wdata_reg    <= 32'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid_i) begin
                        mem_addr_reg <= {addr_i[31:2], 2'b00};
                        offset_reg   <= addr_i[1:0];
                        size_reg     <= size_i;
                        data_reg     <= data_i;
                        err_reg      <= req_err;
                        wait_cnt_reg <= 3'd0;
                        if (req_err) begin
                            state_reg <= S_RESP;
                        end else if (size_i == 2'b10) begin
                            wdata_reg <= data_i;
                            state_reg <= S_WRITE;
                        end else begin
                            state_reg <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    wait_cnt_reg <= 3'd0;
                    state_reg    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_reg == LAST_WAIT) begin
                        wdata_reg <= merged_word;
                        state_reg <= S_WRITE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                S_WRITE: state_reg <= S_RESP;
                S_RESP: begin
                    err_reg   <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_reg == S_IDLE);
    assign mem_rd_o    = (state_reg == S_READ);
    assign mem_wr_o    = (state_reg == S_WRITE);
    assign done_o      = (state_reg == S_RESP);
    assign err_o       = (state_reg == S_RESP) && err_reg;
    assign mem_addr_o  = mem_addr_reg;
    assign mem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_sub_word_store.sv
// Bench for sub_word_store: two instances (read latency 1 and 3) against a
// behavioural memory and a lane-arithmetic reference model.
module tb_sub_word_store;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       done;
    logic [1:0]       err;
    logic [1:0]       mem_rd;
    logic [1:0]       mem_wr;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] data;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] mem_addr;
    logic [1:0][31:0] mem_rdata;
    logic [1:0][31:0] mem_wdata;

    logic [31:0] mem [2][16];
    int          rd_cnt [2];
    logic [3:0]  rd_idx [2];

    int tests  = 0;
    int failed = 0;

    sub_word_store #(.RD_LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .addr_i(addr[0]), .data_i(data[0]), .size_i(size[0]), .done_o(done[0]), .err_o(err[0]),
        .mem_addr_o(mem_addr[0]), .mem_rd_o(mem_rd[0]), .mem_rdata_i(mem_rdata[0]),
        .mem_wr_o(mem_wr[0]), .mem_wdata_o(mem_wdata[0])
    );

    sub_word_store #(.RD_LATENCY(3)) dut_l3 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .addr_i(addr[1]), .data_i(data[1]), .size_i(size[1]), .done_o(done[1]), .err_o(err[1]),
        .mem_addr_o(mem_addr[1]), .mem_rd_o(mem_rd[1]), .mem_rdata_i(mem_rdata[1]),
        .mem_wr_o(mem_wr[1]), .mem_wdata_o(mem_wdata[1])
    );

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Read data is valid only in the cycle exactly RD_LATENCY after the strobe; garbage otherwise.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rd_cnt[u] > 0) begin
                rd_cnt[u] = rd_cnt[u] - 1;
                mem_rdata[u] = (rd_cnt[u] == 0) ? mem[u][rd_idx[u]] : $urandom;
            end else begin
                mem_rdata[u] = $urandom;
            end
            if (mem_rd[u]) begin
                rd_cnt[u] = lat_of(u);
                rd_idx[u] = mem_addr[u][5:2];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge with the unit idle; ends on the negedge of the first idle cycle after done.
    task automatic run(input int u, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit hold, output logic [31:0] wobs);
        int          l;
        int          rd_t;
        int          wr_t;
        int          done_t;
        int          k;
        bit          e;
        logic [31:0] old;
        logic [31:0] exp;
        l    = lat_of(u);
        e    = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
        old  = mem[u][a[5:2]];
        exp  = d;
        wobs = 32'hx;
        k    = int'(a[1:0]);
        if (s == 2'b00)
            exp = (old & ~(32'hFF << (8 * k))) | ({24'd0, d[7:0]} << (8 * k));
        else if (s == 2'b01)
            exp = a[1] ? {d[15:0], old[15:0]} : {old[31:16], d[15:0]};
        rd_t   = (!e && s != 2'b10) ? 1 : 0;
        wr_t   = e ? 0 : ((s == 2'b10) ? 1 : 2 + l);
        done_t = e ? 1 : ((s == 2'b10) ? 2 : 3 + l);

        chk("ready_before", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        addr[u] = a;
        data[u] = d;
        size[u] = s;
        for (int t = 1; t <= done_t + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin
                addr[u] = $urandom;
                data[u] = $urandom;
                size[u] = 2'($urandom_range(0, 3));
                if (!hold) req_valid[u] = 1'b0;
            end
            if (hold && t == done_t) req_valid[u] = 1'b0;
            chk($sformatf("u%0d_strobes_t%0d", u, t), 32'({mem_rd[u], mem_wr[u], done[u], err[u]}),
                32'({t == rd_t, t == wr_t, t == done_t, e && t == done_t}));
            chk($sformatf("u%0d_ready_t%0d", u, t), 32'(req_ready[u]), 32'(t == done_t + 1));
            if (t == rd_t) chk("rd_addr", mem_addr[u], {a[31:2], 2'b00});
            if (t == wr_t) begin
                chk("wr_addr", mem_addr[u], {a[31:2], 2'b00});
                chk("wr_data", mem_wdata[u], exp);
                wobs = mem_wdata[u];
            end
        end
        if (!e) mem[u][a[5:2]] = exp;
        $display("[TB] u%0d addr=%h data=%h size=%0d err=%0d wdata=%h", u, a, d, s, e, wobs);
    endtask

    logic [31:0] w;

    initial begin
        rst = 2'b11;
        req_valid = 2'b00;
        addr = '0;
        data = '0;
        size = '0;
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        rd_idx[0] = 4'd0;
        rd_idx[1] = 4'd0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 16; i++) mem[u][i] = $urandom;
        repeat (2) @(negedge clk);
        rst = 2'b00;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 32'(req_ready[u]), 32'd1);
            chk("rst_strobes", 32'({mem_rd[u], mem_wr[u], done[u], err[u]}), 32'd0);
            chk("rst_addr", mem_addr[u], 32'd0);
            chk("rst_wdata", mem_wdata[u], 32'd0);
        end

        run(0, 32'h100, 32'hDEADBEEF, 2'b10, 0, w);
        chk("word_wdata", w, 32'hDEADBEEF);
        mem[0][0] = 32'h11223344;
        run(0, 32'h203, 32'h000000AB, 2'b00, 0, w);
        chk("byte_wdata", w, 32'hAB223344);
        mem[0][0] = 32'h11223344;
        run(0, 32'h302, 32'h0000CAFE, 2'b01, 0, w);
        chk("half_hi_wdata", w, 32'hCAFE3344);
        mem[0][0] = 32'h11223344;
        run(0, 32'h300, 32'h0000CAFE, 2'b01, 0, w);
        chk("half_lo_wdata", w, 32'h1122CAFE);
        run(0, 32'h101, 32'h12345678, 2'b01, 0, w);
        run(0, 32'h102, 32'h12345678, 2'b10, 0, w);
        run(0, 32'h100, 32'h12345678, 2'b11, 0, w);
        mem[1][0] = 32'hFFFFFFFF;
        run(1, 32'h001, 32'h00000055, 2'b00, 1, w);
        chk("lat3_wdata", w, 32'hFFFF55FF);

        // Reset in the WAIT cycle of a byte store aborts it.
        req_valid[0] = 1'b1;
        addr[0] = 32'h203;
        data[0] = 32'hAB;
        size[0] = 2'b00;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_addr", mem_addr[0], 32'd0);
        chk("abort_wdata", mem_wdata[0], 32'd0);
        for (int t = 0; t < 5; t++) begin
            chk("abort_strobes", 32'({mem_rd[0], mem_wr[0], done[0], err[0]}), 32'd0);
            @(negedge clk);
        end
        $display("[TB] u0 reset during WAIT checked");
        run(0, 32'h100, 32'hCAFEF00D, 2'b10, 0, w);

        // Reset wins over a simultaneous request.
        rst[0] = 1'b1;
        req_valid[0] = 1'b1;
        addr[0] = 32'h100;
        size[0] = 2'b10;
        @(negedge clk);
        chk("rst_vs_req_ready", 32'(req_ready[0]), 32'd1);
        rst[0] = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_vs_req_strobes", 32'({mem_rd[0], mem_wr[0], done[0], err[0]}), 32'd0);
        chk("rst_vs_req_ready2", 32'(req_ready[0]), 32'd1);
        $display("[TB] u0 reset with simultaneous request checked");

        for (int i = 0; i < 40; i++)
            run(i % 2, $urandom, $urandom, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), w);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
